// File: rtl/moore_seq_pkg.sv
// Shared encodings for the Moore ring/bounce sequencer.
//   mode_e : RING (wrap-around) or BOUNCE (ping-pong between the ends)
//   dir_e  : effective step direction, UP = towards out[WIDTH-1]
package moore_seq_pkg;

    typedef enum logic {
        MODE_RING   = 1'b0,
        MODE_BOUNCE = 1'b1
    } mode_e;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

endpackage : moore_seq_pkg

// File: rtl/moore_ring_sequencer_tick_divider.sv
// tick_divider: step-rate prescaler for the sequencer.
// Counts enabled cycles 0..PRESC-1 and raises tick (combinationally from
// the count and en) on the cycle whose edge completes the count. en=0
// freezes the count without clearing it.
// Ports:
//   clk   in  rising-edge clock
//   reset in  synchronous active-high, clears the count
//   clr   in  synchronous clear (position load), clears the count
//   en    in  count enable
//   tick  out high on the edge where the count wraps back to 0
module tick_divider #(
    parameter int PRESC = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    // A 1-bit counter is kept even for PRESC=1; it simply never leaves 0.
    localparam int CW = (PRESC > 1) ? $clog2(PRESC) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          at_end;

    assign at_end = (cnt_q == CW'(PRESC - 1));
    assign tick   = en && at_end;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = at_end ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : tick_divider

// File: rtl/moore_ring_sequencer.sv
// moore_ring_sequencer: one-hot position that steps across WIDTH outputs,
// either wrapping (RING, direction from direccion) or ping-ponging between
// the ends (BOUNCE, direction held in dir_q). All outputs come from
// registers only; there is no input-to-output combinational path.
// There is no valid/ready handshake: every output is valid on every cycle
// after reset, and inputs are sampled on every rising edge.
// Ports:
//   clk, reset         rising-edge clock, synchronous active-high reset
//   en                 step enable (also gates the prescaler)
//   direccion          RING step direction, 1 = up
//   mode               0 = RING, 1 = BOUNCE
//   load, load_pos     synchronous position load, clamped to WIDTH-1
//   out                one-hot decode of pos
//   pos                current position (state, binary)
//   dir_q              current effective direction (state, 1 = up)
//   wrap               one-cycle pulse after a wrap or bounce reversal
module moore_ring_sequencer
    import moore_seq_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int PRESC = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     direccion,
    input  logic                     mode,
    input  logic                     load,
    input  logic [$clog2(WIDTH)-1:0] load_pos,
    output logic [WIDTH-1:0]         out,
    output logic [$clog2(WIDTH)-1:0] pos,
    output logic                     dir_q,
    output logic                     wrap
);

    localparam int PW = $clog2(WIDTH);
    localparam logic [PW-1:0] POS_MAX = PW'(WIDTH - 1);

    logic [PW-1:0] pos_q, pos_d;
    dir_e          dir_state_q, dir_state_d;
    logic          wrap_q, wrap_d;
    logic          tick;
    mode_e         mode_w;
    dir_e          dir_in;
    logic [PW-1:0] load_clamped;

    assign mode_w = mode_e'(mode);
    assign dir_in = dir_e'(direccion);

    // Extra bit so WIDTH itself is representable when WIDTH is a power of 2.
    assign load_clamped = ({1'b0, load_pos} >= (PW + 1)'(WIDTH)) ? POS_MAX : load_pos;

    tick_divider #(
        .PRESC (PRESC)
    ) u_tick_divider (
        .clk   (clk),
        .reset (reset),
        .clr   (load),
        .en    (en),
        .tick  (tick)
    );

    always_comb begin
        pos_d       = pos_q;
        dir_state_d = dir_state_q;
        wrap_d      = 1'b0;
        if (load) begin
            pos_d = load_clamped;
        end else if (mode_w == MODE_RING) begin
            // dir_q follows direccion every edge so a later switch to
            // BOUNCE starts from the most recent requested direction.
            dir_state_d = dir_in;
            if (tick) begin
                if (dir_in == DIR_UP) begin
                    pos_d  = (pos_q == POS_MAX) ? '0 : pos_q + PW'(1);
                    wrap_d = (pos_q == POS_MAX);
                end else begin
                    pos_d  = (pos_q == '0) ? POS_MAX : pos_q - PW'(1);
                    wrap_d = (pos_q == '0);
                end
            end
        end else if (tick) begin
            // Reversal moves off the end in the same step: no dwell.
            if (dir_state_q == DIR_UP && pos_q == POS_MAX) begin
                pos_d       = POS_MAX - PW'(1);
                dir_state_d = DIR_DOWN;
                wrap_d      = 1'b1;
            end else if (dir_state_q == DIR_DOWN && pos_q == '0) begin
                pos_d       = PW'(1);
                dir_state_d = DIR_UP;
                wrap_d      = 1'b1;
            end else if (dir_state_q == DIR_UP) begin
                pos_d = pos_q + PW'(1);
            end else begin
                pos_d = pos_q - PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pos_q       <= '0;
            dir_state_q <= DIR_UP;
            wrap_q      <= 1'b0;
        end else begin
            pos_q       <= pos_d;
            dir_state_q <= dir_state_d;
            wrap_q      <= wrap_d;
        end
    end

    assign out   = WIDTH'(1) << pos_q;
    assign pos   = pos_q;
    assign dir_q = dir_state_q;
    assign wrap  = wrap_q;

endmodule : moore_ring_sequencer
